// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round constants, state encoding,
// word/block types and the RotWord helper.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        FWD,
        REV
    } state_t;

    // Index 0 and 11..15 are padding so a 4-bit round index never leaves the table.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/key_expander.sv
// Sequential AES-128 key schedule, one round key per step.
// Define KEY_REVERSE_EN to build the internal expansion and backward stepping.
module key_expander
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load_key,
    input  logic [127:0] cipher_key,
    input  logic         key_dir,
    input  logic         key_req,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         key_valid,
    output logic         busy
);

    state_t r_state, w_state_next;
    block_t r_key, w_key_next;
    logic [3:0] r_round, w_round_next;

    word_t w_w0, w_w1, w_w2, w_w3;
    word_t w_sbox_in, w_rot, w_sub, w_t;
    logic [3:0] w_rcon_idx;
    block_t w_fwd_key;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;

`ifdef KEY_REVERSE_EN
    block_t w_rev_key;
    word_t  w_rev_w3;
    logic   w_rev_sel;

    // Both directions share the S-boxes: reverse needs SubWord of the recovered w3.
    assign w_rev_sel  = (r_state == REV);
    assign w_rev_w3   = w_w3 ^ w_w2;
    assign w_sbox_in  = w_rev_sel ? w_rev_w3 : w_w3;
    assign w_rcon_idx = w_rev_sel ? r_round : r_round + 4'd1;
    assign w_rev_key  = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_rev_w3};
`else
    logic w_unused_dir;

    assign w_unused_dir = key_dir;
    assign w_sbox_in    = w_w3;
    assign w_rcon_idx   = r_round + 4'd1;
`endif

    assign w_rot = rot_word(w_sbox_in);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[gi*8 +: 8]),
                .o_byte (w_sub[gi*8 +: 8])
            );
        end
    endgenerate

    assign w_t = w_sub ^ {RCON[w_rcon_idx], 24'h0};

    always_comb begin
        word_t f0, f1, f2, f3;
        f0 = w_w0 ^ w_t;
        f1 = w_w1 ^ f0;
        f2 = w_w2 ^ f1;
        f3 = w_w3 ^ f2;
        w_fwd_key = {f0, f1, f2, f3};
    end

    always_comb begin
        w_state_next = r_state;
        w_key_next   = r_key;
        w_round_next = r_round;
        if (load_key) begin
            w_key_next   = cipher_key;
            w_round_next = 4'd0;
`ifdef KEY_REVERSE_EN
            w_state_next = key_dir ? EXPAND : FWD;
`else
            w_state_next = FWD;
`endif
        end else begin
            case (r_state)
`ifdef KEY_REVERSE_EN
                EXPAND: begin
                    w_key_next   = w_fwd_key;
                    w_round_next = r_round + 4'd1;
                    if (r_round == LAST_ROUND - 4'd1) begin
                        w_state_next = REV;
                    end
                end
                REV: begin
                    if (key_req && r_round != 4'd0) begin
                        w_key_next   = w_rev_key;
                        w_round_next = r_round - 4'd1;
                    end
                end
`endif
                FWD: begin
                    if (key_req && r_round != LAST_ROUND) begin
                        w_key_next   = w_fwd_key;
                        w_round_next = r_round + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_round <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_key   <= w_key_next;
            r_round <= w_round_next;
        end
    end

    assign key_valid = (r_state == FWD) || (r_state == REV);
    assign round_key = key_valid ? r_key : '0;
    assign round_num = key_valid ? r_round : 4'd0;

`ifdef KEY_REVERSE_EN
    assign busy = (r_state == EXPAND);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_key_expander.sv
// Scoreboard bench for key_expander: stimulus pushes expected round keys,
// a negedge monitor pops one entry for every cycle the DUT presents key_valid.
module tb_key_expander;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    localparam logic [127:0] FWD_TBL [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         chk;
    } exp_t;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         load_key;
    logic [127:0] cipher_key;
    logic         key_dir;
    logic         key_req;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_valid;
    logic         busy;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    key_expander dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_key   (load_key),
        .cipher_key (cipher_key),
        .key_dir    (key_dir),
        .key_req    (key_req),
        .round_key  (round_key),
        .round_num  (round_num),
        .key_valid  (key_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic void push(input logic [3:0] r, input logic [127:0] k, input logic c);
        exp_t e;
        e.rnd = r;
        e.key = k;
        e.chk = c;
        sb_q.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (key_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got round %0d key %h, required no output", round_num, round_key);
                end else begin
                    e = sb_q.pop_front();
                    chk("round_num", 128'(round_num), 128'(e.rnd));
                    if (e.chk) chk("round_key", round_key, e.key);
                    $display("round %0d key %h", round_num, round_key);
                end
            end else begin
                chk("masked_key", round_key, 128'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst = 1'b0; load_key = 1'b1; cipher_key = K1; key_dir = 1'b0; key_req = 1'b0;
        step(); step();
        chk("rst_valid", 128'(key_valid), 128'h0);
        chk("rst_key",   round_key,       128'h0);
        chk("rst_round", 128'(round_num), 128'h0);
        chk("rst_busy",  128'(busy),      128'h0);
        mon_en = 1'b1;

        // Requests while idle change nothing.
        n_rst = 1'b1; load_key = 1'b0; key_req = 1'b1;
        step(); step();
        chk("idle_valid", 128'(key_valid), 128'h0);
        chk("idle_round", 128'(round_num), 128'h0);

        // Forward schedule, then terminal hold at round 10.
        key_req = 1'b0; load_key = 1'b1; cipher_key = K1; key_dir = 1'b0;
        push(4'd0, K1, 1'b1); step();
        load_key = 1'b0; key_req = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            push(4'(r), FWD_TBL[r], 1'b1); step();
        end
        for (int i = 0; i < 3; i++) begin
            push(4'd10, FWD_TBL[10], 1'b1); step();
        end
        chk("hold_valid", 128'(key_valid), 128'h1);

        // load_key beats key_req in the same cycle.
        load_key = 1'b1; key_req = 1'b1; cipher_key = K2;
        push(4'd0, K2, 1'b1); step();
        load_key = 1'b0;
        push(4'd1, K2_R1, 1'b1); step();

        // Reset in the middle of a forward schedule.
        n_rst = 1'b0; key_req = 1'b0; step();
        chk("midrst_valid", 128'(key_valid), 128'h0);
        chk("midrst_key",   round_key,       128'h0);
        n_rst = 1'b1;

`ifdef KEY_REVERSE_EN
        load_key = 1'b1; cipher_key = K1; key_dir = 1'b1; step();
        load_key = 1'b0; key_req = 1'b1;
        chk("busy_1", 128'(busy), 128'h1);
        for (int i = 2; i <= 10; i++) begin
            step();
            chk("busy_n", 128'(busy), 128'h1);
        end
        push(4'd10, FWD_TBL[10], 1'b1); step();
        chk("busy_done", 128'(busy), 128'h0);
        for (int r = 9; r >= 0; r--) begin
            push(4'(r), FWD_TBL[r], 1'b1); step();
        end
        for (int i = 0; i < 2; i++) begin
            push(4'd0, FWD_TBL[0], 1'b1); step();
        end

        // Restart during expansion cycle 5.
        load_key = 1'b1; cipher_key = K1; key_dir = 1'b1; key_req = 1'b0; step();
        load_key = 1'b0;
        for (int i = 0; i < 4; i++) step();
        load_key = 1'b1; cipher_key = K2; step();
        load_key = 1'b0;
        chk("rbusy_1", 128'(busy), 128'h1);
        for (int i = 2; i <= 10; i++) begin
            step();
            chk("rbusy_n", 128'(busy), 128'h1);
        end
        push(4'd10, K2_R10, 1'b1); step();
        chk("rbusy_done", 128'(busy), 128'h0);
        key_req = 1'b1;
        for (int r = 9; r >= 0; r--) begin
            push(4'(r), (r == 1) ? K2_R1 : K2, (r <= 1)); step();
        end
        n_rst = 1'b0; step();
        n_rst = 1'b1;
`else
        // Without reverse support key_dir=1 runs forward.
        load_key = 1'b1; cipher_key = K1; key_dir = 1'b1; key_req = 1'b0;
        push(4'd0, K1, 1'b1); step();
        chk("nobusy", 128'(busy), 128'h0);
        load_key = 1'b0; key_req = 1'b1;
        push(4'd1, FWD_TBL[1], 1'b1); step();
        n_rst = 1'b0; step();
        n_rst = 1'b1;
`endif

        key_req = 1'b0;
        step();
        chk("sb_drained", 128'(sb_q.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
